// File: rtl/rf_pkg.sv
// Shared constants and types for the register-file write-back path.
// Holds data/address widths, requester IDs and the write-entry struct.
// No logic, no latency, no backpressure.
package rf_pkg;

  localparam int XLEN = 32;
  localparam int RAW  = 5;

  // Requester IDs double as slot indices and as PRI/OLD encodings
  localparam bit REQ_ALU = 1'b0;
  localparam bit REQ_LSU = 1'b1;

  typedef struct packed {
    logic [RAW-1:0]  addr;
    logic [XLEN-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/rf_wb_slot.sv
// One-entry write holding slot with FULL flag.
// Latency: an accepted write is visible on full/addr/data the cycle after acceptance.
// Backpressure: rdy = empty or draining this cycle, so a slot can refill while it drains.
module rf_wb_slot #(
  parameter int XLEN = 32,
  parameter int RAW  = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            vld,
  input  logic [RAW-1:0]  req_addr,
  input  logic [XLEN-1:0] req_data,
  input  logic            drain,
  output logic            rdy,
  output logic            full,
  output logic [RAW-1:0]  addr,
  output logic [XLEN-1:0] data
);

  // Ready only depends on registered state (full) and the grant, which is itself registered-state driven
  assign rdy = !full || drain;

  // Load wins over drain so accept-and-drain in one cycle keeps the slot occupied
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      addr <= '0;
      data <= '0;
    end else if (vld && rdy) begin
      full <= 1'b1;
      addr <= req_addr;
      data <= req_data;
    end else if (drain) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin write-back arbiter feeding the register file's single write port (A3/WE3/WD3).
// Latency: a write accepted at edge N drives the write port in cycle N+1; one write per cycle.
// Backpressure: R_i drops only while slot i holds an entry that lost arbitration.
// Optional hazard outputs (QA1/QA2 -> HZ1/HZ2) are built when RF_WB_HAZARD_EN is defined.
module rf_wb_arbiter #(
  parameter int XLEN = rf_pkg::XLEN,
  parameter int RAW  = rf_pkg::RAW
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            V0,
  input  logic [RAW-1:0]  A0,
  input  logic [XLEN-1:0] D0,
  output logic            R0,
  input  logic            V1,
  input  logic [RAW-1:0]  A1W,
  input  logic [XLEN-1:0] D1,
  output logic            R1,
  output logic [RAW-1:0]  A3,
  output logic            WE3,
  output logic [XLEN-1:0] WD3
`ifdef RF_WB_HAZARD_EN
  ,
  input  logic [RAW-1:0]  QA1,
  input  logic [RAW-1:0]  QA2,
  output logic            HZ1,
  output logic            HZ2
`endif
);

  import rf_pkg::*;

  logic            full0, full1;
  logic [RAW-1:0]  addr0, addr1;
  logic [XLEN-1:0] data0, data1;
  logic            ld0, ld1;
  logic            pri;   // slot favoured when both are full and destinations differ
  logic            old;   // slot holding the older entry when both are full
  logic            sel;
  logic [1:0]      gnt;

  rf_wb_slot #(.XLEN(XLEN), .RAW(RAW)) u_slot0 (
    .clk(CLK), .rst_n(RST_N), .vld(V0), .req_addr(A0), .req_data(D0),
    .drain(gnt[REQ_ALU]), .rdy(R0), .full(full0), .addr(addr0), .data(data0)
  );

  rf_wb_slot #(.XLEN(XLEN), .RAW(RAW)) u_slot1 (
    .clk(CLK), .rst_n(RST_N), .vld(V1), .req_addr(A1W), .req_data(D1),
    .drain(gnt[REQ_LSU]), .rdy(R1), .full(full1), .addr(addr1), .data(data1)
  );

  assign ld0 = V0 && R0;
  assign ld1 = V1 && R1;

  // Grant: lone full slot wins; two full slots to the same real register keep program order, else round-robin
  always_comb begin
    sel = pri;
    if (addr0 == addr1 && addr0 != '0) sel = old;
    if (full0 && full1) gnt = sel ? 2'b10 : 2'b01;
    else                gnt = {full1, full0};
  end

  // Write-port mux; an x0 entry is consumed with the enable held low
  always_comb begin
    A3  = '0;
    WD3 = '0;
    WE3 = 1'b0;
    if (gnt[REQ_ALU]) begin
      A3  = addr0;
      WD3 = data0;
      WE3 = (addr0 != '0);
    end else if (gnt[REQ_LSU]) begin
      A3  = addr1;
      WD3 = data1;
      WE3 = (addr1 != '0);
    end
  end

  // Round-robin pointer moves to the other slot after every grant
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)              pri <= REQ_ALU;
    else if (gnt[REQ_ALU])   pri <= REQ_LSU;
    else if (gnt[REQ_LSU])   pri <= REQ_ALU;
  end

  // Age tracking: a slot loaded behind a waiting slot is younger; simultaneous loads favour the ALU slot
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                             old <= REQ_ALU;
    else if (ld0 && ld1)                    old <= REQ_ALU;
    else if (ld0 && full1 && !gnt[REQ_LSU]) old <= REQ_LSU;
    else if (ld1 && full0 && !gnt[REQ_ALU]) old <= REQ_ALU;
  end

`ifdef RF_WB_HAZARD_EN
  // Pending-write hazard flags for decode; x0 never reports a hazard
  always_comb begin
    HZ1 = (QA1 != '0) && ((full0 && addr0 == QA1) || (full1 && addr1 == QA1));
    HZ2 = (QA2 != '0) && ((full0 && addr0 == QA2) || (full1 && addr1 == QA2));
  end
`endif

endmodule
